// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, frame checks and FWFT FIFO
//
// Optional feature: define PS2_RX_PARITY_CHECK_EN to enforce odd parity;
// otherwise the parity bit is sampled but ignored and parity_err stays 0.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-low reset
//   ps2d, ps2c    asynchronous PS/2 data / clock pins
//   rx_en         allows a new frame to start (a frame in progress always completes)
//   rd_en         pop FIFO head (ignored when empty)
//   dout          FIFO head byte; holds the last popped byte while empty
//   empty, full   FIFO status
//   count         FIFO occupancy
//   rx_done_tick  pulse: good byte written
//   parity_err    pulse: frame dropped for bad parity
//   frame_err     pulse: bad stop bit or inter-bit timeout
//   overflow      pulse: good byte dropped, FIFO full
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rx_en,
  input  logic                          rd_en,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rx_done_tick,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_COMMIT} state_e;

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  fclk_q;
  logic                  all_lo, all_hi, fall_tick, ps2d_s;

  state_e                state_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            data_q;
  logic                  par_q, stop_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  busy, timeout, commit, stop_bad, par_bad, good, wr, do_rd;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic [7:0]            last_q;

  // Input conditioning: 2-FF synchronisers, then a history-based clock filter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      hist_q   <= '1;
      fclk_q   <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      hist_q   <= {hist_q[FILTER_LEN-2:0], c_sync_q[1]};
      if (all_hi)      fclk_q <= 1'b1;
      else if (all_lo) fclk_q <= 1'b0;
    end
  end

  assign all_lo    = (hist_q == '0);
  assign all_hi    = &hist_q;
  assign fall_tick = fclk_q & all_lo;   // the cycle in which fclk is about to drop
  assign ps2d_s    = d_sync_q[1];

  // Timeout fires on the cycle that would make the counter reach TIMEOUT_CYCLES.
  assign busy    = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
  assign timeout = busy && !fall_tick && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          to_cnt_q <= '0;
          if (fall_tick && rx_en && !ps2d_s) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (timeout) begin
            state_q  <= S_IDLE;
            to_cnt_q <= '0;
          end else if (fall_tick) begin
            to_cnt_q  <= '0;
            data_q    <= {ps2d_s, data_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (timeout) begin
            state_q  <= S_IDLE;
            to_cnt_q <= '0;
          end else if (fall_tick) begin
            to_cnt_q <= '0;
            par_q    <= ps2d_s;
            state_q  <= S_STOP;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (timeout) begin
            state_q  <= S_IDLE;
            to_cnt_q <= '0;
          end else if (fall_tick) begin
            to_cnt_q <= '0;
            stop_q   <= ps2d_s;
            state_q  <= S_COMMIT;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Frame evaluation in COMMIT; overflow depends on rd_en in that same cycle.
  assign commit   = (state_q == S_COMMIT);
  assign stop_bad = ~stop_q;
`ifdef PS2_RX_PARITY_CHECK_EN
  assign par_bad  = ~(^{data_q, par_q});
`else
  logic unused_par;
  assign unused_par = par_q;
  assign par_bad    = 1'b0;
`endif

  assign good         = commit & ~stop_bad & ~par_bad;
  assign frame_err    = timeout | (commit & stop_bad);
  assign parity_err   = commit & ~stop_bad & par_bad;
  assign overflow     = good & full & ~rd_en;
  assign wr           = good & (~full | rd_en);
  assign rx_done_tick = wr;
  assign do_rd        = rd_en & ~empty;

  // First-word-fall-through FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr) mem_q[wr_ptr_q] <= data_q;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;
  assign dout  = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int FL   = 8;
  localparam int FD   = 4;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset, ps2d, ps2c, rx_en, rd_en;
  logic [7:0] dout;
  logic       empty, full;
  logic [2:0] count;
  logic       rx_done_tick, parity_err, frame_err, overflow;

  int n_vec = 0, n_mis = 0;
  int cyc = 0;
  int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  int done_cyc = 0, ferr_cyc = 0, fall_cyc = 0;

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .rx_done_tick(rx_done_tick), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_done_tick) begin n_done++; done_cyc = cyc; end
      if (parity_err)   n_perr++;
      if (frame_err)    begin n_ferr++; ferr_cyc = cyc; end
      if (overflow)     n_ovf++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    logic p;
    p = ~(^b);
    if (!par_ok) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit rd_commit);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      step(HALF / 2);
      ps2c = 1'b0;
      fall_cyc = cyc;
      if (rd_commit && i == nbits - 1) begin
        step(FL + 3);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        step(HALF - FL - 4);
      end else begin
        step(HALF);
      end
      ps2c = 1'b1;
      step(HALF / 2);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(make_frame(b, 1'b1, 1'b1), 11, 1'b0);
  endtask

  task automatic pop(input string tag, input logic [7:0] want);
    @(negedge clk);
    chk(tag, 32'(dout), 32'(want));
    @(posedge clk);
    #1;
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  initial begin
    int d0, p0, f0, o0;
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, f0, o0;
    reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(dout),  32'h00);
    chk("rst_pulses", 32'({rx_done_tick, parity_err, frame_err, overflow}), 32'd0);
    step(1);
    reset = 1'b1;
    step(2);

    // Single good 0x5A frame.
    d0 = n_done;
    send(8'h5A);
    chk("5a_done", n_done - d0, 1);
    chk("5a_done_cycle", done_cyc, fall_cyc + FL + 3);
    @(negedge clk);
    chk("5a_count", 32'(count), 32'd1);
    chk("5a_empty", 32'(empty), 32'd0);
    pop("5a_dout", 8'h5A);
    @(negedge clk);
    chk("5a_empty_after_pop", 32'(empty), 32'd1);
    chk("5a_dout_held", 32'(dout), 32'h5A);

    // Bad parity.
    d0 = n_done; p0 = n_perr;
    send_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
    chk("par_err_pulse", n_perr - p0, 1);
    chk("par_done", n_done - d0, 0);
    @(negedge clk);
    chk("par_count", 32'(count), 32'd0);
`else
    chk("par_err_pulse", n_perr - p0, 0);
    chk("par_done", n_done - d0, 1);
    @(negedge clk);
    chk("par_count", 32'(count), 32'd1);
    pop("par_dout", 8'h5A);
`endif

    // Bad stop bit.
    d0 = n_done; f0 = n_ferr;
    send_bits(make_frame(8'h33, 1'b1, 1'b0), 11, 1'b0);
    chk("stop_ferr", n_ferr - f0, 1);
    chk("stop_done", n_done - d0, 0);
    @(negedge clk);
    chk("stop_count", 32'(count), 32'd0);

    // Burst of three, then drain in order.
    send(8'hE0); send(8'hF0); send(8'h1C);
    @(negedge clk);
    chk("burst_count", 32'(count), 32'd3);
    pop("burst_0", 8'hE0);
    pop("burst_1", 8'hF0);
    pop("burst_2", 8'h1C);
    @(negedge clk);
    chk("burst_empty", 32'(empty), 32'd1);

    // rx_en low: frame is not started.
    d0 = n_done; rx_en = 1'b0;
    send(8'h33);
    rx_en = 1'b1;
    chk("rxen_done", n_done - d0, 0);
    @(negedge clk);
    chk("rxen_count", 32'(count), 32'd0);

    // Overflow with depth 4.
    d0 = n_done; o0 = n_ovf;
    send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h15);
    chk("ovf_pulse", n_ovf - o0, 1);
    chk("ovf_done", n_done - d0, 4);
    @(negedge clk);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    d0 = n_done; o0 = n_ovf;
    send_bits(make_frame(8'h16, 1'b1, 1'b1), 11, 1'b1);
    chk("rdw_no_ovf", n_ovf - o0, 0);
    chk("rdw_done", n_done - d0, 1);
    @(negedge clk);
    chk("rdw_count", 32'(count), 32'd4);
    chk("rdw_full", 32'(full), 32'd1);
    pop("rdw_0", 8'h12);
    pop("rdw_1", 8'h13);
    pop("rdw_2", 8'h14);
    pop("rdw_3", 8'h16);
    @(negedge clk);
    chk("rdw_empty", 32'(empty), 32'd1);

    // Inter-bit timeout after 4 data bits.
    f0 = n_ferr; d0 = n_done;
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 5, 1'b0);
    step(TO + 40);
    chk("to_ferr", n_ferr - f0, 1);
    chk("to_cycle", ferr_cyc, fall_cyc + FL + 2 + TO);
    chk("to_done", n_done - d0, 0);
    send(8'h5A);
    chk("to_recover_done", n_done - d0, 1);
    pop("to_recover_dout", 8'h5A);

    // Short low glitch with data low must not start a frame.
    d0 = n_done; f0 = n_ferr;
    ps2d = 1'b0; ps2c = 1'b0;
    step(3);
    ps2c = 1'b1;
    step(30);
    send(8'h5A);
    chk("glitch_done", n_done - d0, 1);
    chk("glitch_ferr", n_ferr - f0, 0);
    pop("glitch_dout", 8'h5A);

    // Reset mid-frame with a non-empty FIFO.
    send(8'h77);
    send_bits(make_frame(8'h3C, 1'b1, 1'b1), 4, 1'b0);
    reset = 1'b0;
    step(2);
    @(negedge clk);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_full",  32'(full),  32'd0);
    chk("mrst_dout",  32'(dout),  32'h00);
    step(1);
    reset = 1'b1;
    step(5);
    d0 = n_done;
    send(8'h5A);
    chk("mrst_recover_done", n_done - d0, 1);
    pop("mrst_recover_dout", 8'h5A);
    @(negedge clk);
    chk("mrst_final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
